// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, flag bit positions and the flag bundle.
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int FLAG_W = 4;

  // Bit positions of each flag inside a packed flag vector.
  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_NEG    = 1;
  localparam int FLAG_BORROW = 2;
  localparam int FLAG_OVF    = 3;

  typedef struct packed {
    logic ovf;
    logic borrow;
    logic neg;
    logic zero;
  } alu_flags_t;

  function automatic alu_flags_t make_flags(input logic ovf, input logic borrow,
                                            input logic neg, input logic zero);
    alu_flags_t f;
    f.ovf    = ovf;
    f.borrow = borrow;
    f.neg    = neg;
    f.zero   = zero;
    return f;
  endfunction

endpackage

// File: rtl/sub_adder.sv
// WIDTH-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained
// through group generate/propagate terms. Operands are zero-padded to a whole group.
module sub_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_inv,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGRP = (WIDTH + 3) / 4;
  localparam int PW   = NGRP * 4;

  logic [PW-1:0] a_ext_s;
  logic [PW-1:0] b_ext_s;
  logic [PW-1:0] g_s;
  logic [PW-1:0] p_s;
  logic [PW:0]   carry_s;
  logic [PW-1:0] sum_ext_s;
  logic          grp_g_s;
  logic          grp_p_s;

  // Generate/propagate, in-group lookahead carries and group-level carry chain.
  always_comb begin
    a_ext_s            = '0;
    b_ext_s            = '0;
    a_ext_s[WIDTH-1:0] = a;
    b_ext_s[WIDTH-1:0] = b_inv;
    g_s                = a_ext_s & b_ext_s;
    p_s                = a_ext_s ^ b_ext_s;
    carry_s            = '0;
    carry_s[0]         = cin;
    grp_g_s            = 1'b0;
    grp_p_s            = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      carry_s[4*k+1] = g_s[4*k]
                     | (p_s[4*k] & carry_s[4*k]);
      carry_s[4*k+2] = g_s[4*k+1]
                     | (p_s[4*k+1] & g_s[4*k])
                     | (p_s[4*k+1] & p_s[4*k] & carry_s[4*k]);
      carry_s[4*k+3] = g_s[4*k+2]
                     | (p_s[4*k+2] & g_s[4*k+1])
                     | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                     | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & carry_s[4*k]);
      grp_g_s = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
      grp_p_s = p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k];
      carry_s[4*k+4] = grp_g_s | (grp_p_s & carry_s[4*k]);
    end
    sum_ext_s = p_s ^ carry_s[PW-1:0];
  end

  assign sum  = sum_ext_s[WIDTH-1:0];
  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/sub_unit.sv
// EX-stage subtractor: combinational a - b with status flags, plus a one-cycle
// registered copy qualified by out_valid for pipelined consumers. WIDTH must be >= 2.
module sub_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             borrow,
  output logic             overflow,
  output logic [WIDTH-1:0] result_q,
  output logic [FLAG_W-1:0] flags_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] b_inv_s;
  logic [WIDTH-1:0] result_s;
  logic             cout_s;
  logic             overflow_s;
  alu_flags_t       flags_s;

  logic [WIDTH-1:0] result_q_r;
  alu_flags_t       flags_q_r;
  logic             out_valid_r;

  assign b_inv_s = ~b;

  sub_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a     (a),
    .b_inv (b_inv_s),
    .cin   (1'b1),
    .sum   (result_s),
    .cout  (cout_s)
  );

  // Signed overflow only when operand signs differ and the result sign leaves a's sign.
  assign overflow_s = (a[WIDTH-1] != b[WIDTH-1]) && (result_s[WIDTH-1] != a[WIDTH-1]);
  assign flags_s    = make_flags(overflow_s, ~cout_s, result_s[WIDTH-1], ~|result_s);

  assign result   = result_s;
  assign zero     = flags_s.zero;
  assign negative = flags_s.neg;
  assign borrow   = flags_s.borrow;
  assign overflow = flags_s.ovf;

  // Output stage: reset clears, in_valid captures, otherwise data holds and valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q_r  <= '0;
      flags_q_r   <= '0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      result_q_r  <= result_s;
      flags_q_r   <= flags_s;
      out_valid_r <= 1'b1;
    end else begin
      result_q_r  <= result_q_r;
      flags_q_r   <= flags_q_r;
      out_valid_r <= 1'b0;
    end
  end

  assign result_q  = result_q_r;
  assign flags_q   = flags_q_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sub_unit.sv
// Randomized scoreboard bench for sub_unit: a driver pushes the expected registered
// state per cycle, a monitor pops and compares after each rising edge.
module tb_sub_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_valid;
  logic [W-1:0]  result;
  logic          zero;
  logic          negative;
  logic          borrow;
  logic          overflow;
  logic [W-1:0]  result_q;
  logic [3:0]    flags_q;
  logic          out_valid;

  sub_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .borrow    (borrow),
    .overflow  (overflow),
    .result_q  (result_q),
    .flags_q   (flags_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [W-1:0]  res;
    logic [3:0]    flg;
  } exp_t;

  exp_t         sb_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] hold_res = '0;
  logic [3:0]   hold_flg = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, flags from their arithmetic definitions.
  function automatic void ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [3:0] f);
    longint sd;
    longint ux;
    longint uy;
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    sd = longint'($signed(x)) - longint'($signed(y));
    r  = W'(ux - uy);
    f[3] = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    f[2] = ux < uy;
    f[1] = sd < 0 ? !f[3] : f[3];
    f[0] = (r == '0);
  endfunction

  task automatic cycle(input logic r_v, input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] er;
    logic [3:0]   ef;
    exp_t         e;
    rst      = r_v;
    in_valid = iv;
    a        = av;
    b        = bv;
    ref_sub(av, bv, er, ef);
    if (r_v) begin
      hold_res = '0;
      hold_flg = '0;
      e.vld    = 1'b0;
    end else if (iv) begin
      hold_res = er;
      hold_flg = ef;
      e.vld    = 1'b1;
    end else begin
      e.vld    = 1'b0;
    end
    e.res = hold_res;
    e.flg = hold_flg;
    sb_q.push_back(e);
    #1;
    check("comb_result", 64'(result), 64'(er));
    check("comb_flags", 64'({overflow, borrow, negative, zero}), 64'(ef));
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: one scoreboard entry per cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        if (out_valid !== 1'b0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("out_valid", 64'(out_valid), 64'(e.vld));
        check("result_q", 64'(result_q), 64'(e.res));
        check("flags_q", 64'(flags_q), 64'(e.flg));
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         riv;
    logic         rrst;
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 32'd7, 32'd3);
    // Directed values from the boundary list.
    cycle(1'b0, 1'b1, 32'd20, 32'd5);
    cycle(1'b0, 1'b1, 32'd0, 32'd1);
    cycle(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FF9C);
    cycle(1'b0, 1'b1, 32'h8000_0000, 32'd1);
    cycle(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'd1, 32'd2);
    cycle(1'b0, 1'b0, 32'd9, 32'd9);
    // Back-to-back stream with reset landing on the second operation.
    cycle(1'b0, 1'b1, 32'd100, 32'd1);
    cycle(1'b1, 1'b1, 32'd200, 32'd2);
    cycle(1'b0, 1'b1, 32'd300, 32'd3);
    cycle(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 10000; i++) begin
      ra   = pick();
      rb   = ($urandom % 6 == 0) ? ra : pick();
      riv  = 1'($urandom % 2);
      rrst = ($urandom % 64) == 0;
      cycle(rrst, riv, ra, rb);
    end
    cycle(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against any stall in the stimulus loop.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sub_unit.md
Name: sub_unit

Overview:
- Two's-complement subtractor for the EX-stage ALU of the RISC-V core; computes result = a - b.
- The combinational result is valid in the same cycle as the inputs, for direct ALU muxing.
- Also produces status flags and a one-stage registered copy of result and flags, qualified by a valid bit, for pipelined consumers.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- in_valid  input  1  operands on a/b are to be captured this cycle.
- result  output  WIDTH  combinational a - b, modulo 2^WIDTH.
- zero  output  1  combinational; result == 0.
- negative  output  1  combinational; result[WIDTH-1].
- borrow  output  1  combinational; unsigned a < b.
- overflow  output  1  combinational; signed overflow of a - b.
- result_q  output  WIDTH  registered result.
- flags_q  output  4  registered {overflow, borrow, negative, zero}.
- out_valid  output  1  result_q/flags_q hold a captured operation.

Behaviour:
- Arithmetic: result = a + ~b + 1 (WIDTH+1-bit internal sum).
  - carry_out = sum[WIDTH]; borrow = ~carry_out.
  - Signed and unsigned operands use the same bit pattern; wrap-around is silent.
- overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]).
- zero = ~|result; negative = result[MSB].
- Combinational path: result and the four flags depend only on a and b (no clock, no reset influence). They settle within the same cycle, with zero cycles of latency.
- Registered path, at each rising clk edge:
  - If rst=1: result_q <= 0, flags_q <= 0, out_valid <= 0. Reset wins over a simultaneous in_valid.
  - Else if in_valid=1: result_q <= result, flags_q <= {overflow, borrow, negative, zero}, out_valid <= 1.
  - Else: result_q and flags_q hold their values, out_valid <= 0.
- Latency on the registered path is exactly 1 cycle. There is no backpressure; every in_valid cycle produces an out_valid cycle one clock later.
- Reset asserted mid-stream discards the in-flight capture; out_valid is 0 on the cycle after reset, and the first capture after reset deasserts appears one cycle after its in_valid.
- Boundary values:
  - a == b gives zero=1, borrow=0, overflow=0.
  - 0 - 1 gives all-ones, negative=1, borrow=1, overflow=0.
  - MIN_INT - 1 gives MAX_INT, overflow=1.
  - MAX_INT - (-1) gives MIN_INT, overflow=1.
- No X propagation from the registered outputs after reset; no latches.

Decomposition:
- Shared package alu_pkg: XLEN = 32; a flag-index constant for each bit of flags_q (ZERO=0, NEG=1, BORROW=2, OVF=3); a packed struct alu_flags_t {ovf, borrow, neg, zero}.
- One sub-module is natural: sub_adder, a WIDTH-bit carry-lookahead adder (a, b_inv, cin -> sum, cout) built from 4-bit lookahead groups.
  - sub_unit instantiates it with b_inv = ~b and cin = 1.
  - sub_unit adds flag logic and the output register stage.

Test Plan:
- a=20, b=5 -> result=15, zero=0, negative=0, borrow=0, overflow=0; with in_valid=1, result_q=15 and out_valid=1 one cycle later.
- a=0, b=1 -> result=0xFFFFFFFF (signed -1), negative=1, borrow=1, overflow=0.
- a=-100, b=-100 (0xFFFFFF9C both) -> result=0, zero=1, borrow=0, overflow=0.
- a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1, borrow=0. Also a=0x7FFFFFFF, b=0xFFFFFFFF -> result=0x80000000, overflow=1, borrow=1.
- Stream 3 back-to-back in_valid operations with rst asserted together with the 2nd -> cycle after the rst edge: result_q=0, flags_q=0, out_valid=0. The 3rd operation, issued after rst drops, appears one cycle later.
- Random 10k signed/unsigned pairs with in_valid randomly toggled -> result, flags and registered outputs match a reference model computing (a - b) mod 2^32 and the flag equations; out_valid equals in_valid delayed by one cycle (0 under reset).
